// File: rtl/brq_pkg.sv
// ---------------------------------------------------------------------------
// brq_pkg
// Shared types and constants for the branch resolve queue.
//   BRQ_XLEN    : PC / target width of a queue entry
//   PC_STEP     : sequential fall-through distance for a branch instruction
//   brq_entry_t : one in-flight predicted branch {pc, pred_taken, pred_tgt}
//   brq_ptr_w() : head/tail pointer width for a given queue depth
// ---------------------------------------------------------------------------
package brq_pkg;

    localparam int BRQ_XLEN = 32;

    localparam logic [BRQ_XLEN-1:0] PC_STEP = BRQ_XLEN'(4);

    typedef struct packed {
        logic [BRQ_XLEN-1:0] pc;
        logic                pred_taken;
        logic [BRQ_XLEN-1:0] pred_tgt;
    } brq_entry_t;

    // Pointer width; a depth of 1 still needs one bit to form a legal vector.
    function automatic int brq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
// In-order queue of in-flight predicted branches between fetch/predict and
// execute. Fetch enqueues each branch with its predicted direction/target;
// execute resolves the oldest entry. A wrong direction or wrong taken target
// raises a one-cycle mispredict with the correct redirect PC and flushes every
// younger (wrong-path) entry. Every resolve also produces a predictor
// training strobe.
//
// Optional feature macro: BRQ_STATS_EN
//   defined   -> adds o_stat_resolved / o_stat_mispred saturating counters
//   undefined -> counters and their ports are absent
//
// Ports
//   clk               clock, all state on rising edge
//   i_reset           synchronous, active-high reset
//   i_enq_valid       fetch presents a predicted branch
//   o_enq_ready       queue can accept (not full, no flush pulse this cycle)
//   i_enq_pc          branch instruction PC
//   i_enq_pred_taken  predicted direction
//   i_enq_pred_tgt    predicted target (meaningful only when predicted taken)
//   i_res_valid       execute resolves the oldest queued branch
//   i_res_taken       actual direction
//   i_res_tgt         actual taken target
//   o_mispredict      one-cycle pulse: flush + redirect
//   o_redirect_pc     correct next PC, valid with o_mispredict
//   o_upd_valid       predictor training strobe, one per resolve
//   o_upd_pc          trained branch PC
//   o_upd_taken       trained outcome
//   o_count           occupancy
//   o_res_err         sticky: resolve seen while empty
//   o_stat_resolved   (BRQ_STATS_EN) resolves seen, saturating
//   o_stat_mispred    (BRQ_STATS_EN) mispredicts seen, saturating
// ---------------------------------------------------------------------------
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = BRQ_XLEN
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [XLEN-1:0]            i_enq_pc,
    input  logic                       i_enq_pred_taken,
    input  logic [XLEN-1:0]            i_enq_pred_tgt,
    input  logic                       i_res_valid,
    input  logic                       i_res_taken,
    input  logic [XLEN-1:0]            i_res_tgt,
    output logic                       o_mispredict,
    output logic [XLEN-1:0]            o_redirect_pc,
    output logic                       o_upd_valid,
    output logic [XLEN-1:0]            o_upd_pc,
    output logic                       o_upd_taken,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_res_err
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]                o_stat_resolved,
    output logic [31:0]                o_stat_mispred
`endif
);

    localparam int PTR_W = brq_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage and pointers
    brq_entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    // Registered outputs
    logic                   r_mispredict;
    logic [XLEN-1:0]        r_redirect_pc;
    logic                   r_upd_valid;
    logic [XLEN-1:0]        r_upd_pc;
    logic                   r_upd_taken;
    logic                   r_res_err;

    // Combinational resolve path
    brq_entry_t             w_head_entry;
    logic                   w_enq_ready;
    logic                   w_enq_fire;
    logic                   w_res_fire;
    logic                   w_dir_wrong;
    logic                   w_tgt_wrong;
    logic                   w_mispred;
    logic                   w_flush;
    logic [XLEN-1:0]        w_redirect_pc;

    // Ready depends only on the current occupancy and the flush pulse, so a
    // full queue cannot accept even when the oldest entry resolves this cycle.
    assign w_enq_ready  = (r_count != FULL_CNT) && !r_mispredict;
    assign w_enq_fire   = i_enq_valid && w_enq_ready;
    assign w_res_fire   = i_res_valid && (r_count != '0);

    assign w_head_entry = r_mem[r_head];
    assign w_dir_wrong  = (i_res_taken != w_head_entry.pred_taken);
    // Target only matters when both predicted and actual say taken.
    assign w_tgt_wrong  = i_res_taken && w_head_entry.pred_taken &&
                          (i_res_tgt != w_head_entry.pred_tgt);
    assign w_mispred    = w_dir_wrong || w_tgt_wrong;
    assign w_flush      = w_res_fire && w_mispred;

    // Fall-through wraps modulo 2^XLEN; the carry is deliberately dropped.
    assign w_redirect_pc = i_res_taken ? i_res_tgt : (w_head_entry.pc + PC_STEP);

    // NOTE: entry storage has no reset; occupancy tracking alone decides which
    // entries are live, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_enq_fire && !w_flush) begin
            r_mem[r_tail] <= '{pc: i_enq_pc,
                               pred_taken: i_enq_pred_taken,
                               pred_tgt: i_enq_pred_tgt};
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally at their bit width.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            // Everything younger than the mispredicted branch is wrong-path,
            // including an enqueue arriving on this same edge.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_res_fire) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({w_enq_fire, w_res_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Resolve results, registered once so they appear one cycle after the
    // resolving edge. PC/outcome fields hold their last value between strobes.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_res_err     <= 1'b0;
        end else begin
            r_mispredict <= w_flush;
            r_upd_valid  <= w_res_fire;
            if (w_res_fire) begin
                r_redirect_pc <= w_redirect_pc;
                r_upd_pc      <= w_head_entry.pc;
                r_upd_taken   <= i_res_taken;
            end
            // Sticky until reset: execute resolved a branch that was never queued.
            if (i_res_valid && (r_count == '0)) begin
                r_res_err <= 1'b1;
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_res_fire && (r_stat_resolved != '1)) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_flush && (r_stat_mispred != '1)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign o_stat_resolved = r_stat_resolved;
    assign o_stat_mispred  = r_stat_mispred;
`endif

    assign o_enq_ready   = w_enq_ready;
    assign o_mispredict  = r_mispredict;
    assign o_redirect_pc = r_redirect_pc;
    assign o_upd_valid   = r_upd_valid;
    assign o_upd_pc      = r_upd_pc;
    assign o_upd_taken   = r_upd_taken;
    assign o_count       = r_count;
    assign o_res_err     = r_res_err;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_queue
// Directed scenarios plus a randomized run against a queue-based reference
// model of the branch resolve queue (DEPTH=4, XLEN=32).
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            enq_valid;
    logic            enq_ready;
    logic [XLEN-1:0] enq_pc;
    logic            enq_pred_taken;
    logic [XLEN-1:0] enq_pred_tgt;
    logic            res_valid;
    logic            res_taken;
    logic [XLEN-1:0] res_tgt;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [2:0]      count;
    logic            res_err;
`ifdef BRQ_STATS_EN
    logic [31:0]     stat_resolved;
    logic [31:0]     stat_mispred;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .i_reset          (reset),
        .i_enq_valid      (enq_valid),
        .o_enq_ready      (enq_ready),
        .i_enq_pc         (enq_pc),
        .i_enq_pred_taken (enq_pred_taken),
        .i_enq_pred_tgt   (enq_pred_tgt),
        .i_res_valid      (res_valid),
        .i_res_taken      (res_taken),
        .i_res_tgt        (res_tgt),
        .o_mispredict     (mispredict),
        .o_redirect_pc    (redirect_pc),
        .o_upd_valid      (upd_valid),
        .o_upd_pc         (upd_pc),
        .o_upd_taken      (upd_taken),
        .o_count          (count),
        .o_res_err        (res_err)
`ifdef BRQ_STATS_EN
        ,
        .o_stat_resolved  (stat_resolved),
        .o_stat_mispred   (stat_mispred)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } br_t;

    br_t         mq[$];
    logic        m_mis;
    logic        m_upd_v;
    logic        m_upd_t;
    logic        m_err;
    logic [31:0] m_redir;
    logic [31:0] m_upd_pc;

    task automatic model_reset();
        mq.delete();
        m_mis = 0; m_upd_v = 0; m_upd_t = 0; m_err = 0;
        m_redir = 0; m_upd_pc = 0;
    endtask

    function automatic logic model_ready();
        return (mq.size() < DEPTH) && !m_mis;
    endfunction

    // Drive one clock's worth of inputs, advance the model, then step to
    // 1 time unit after the rising edge where registered outputs are stable.
    task automatic cycle(input logic ev, input logic [31:0] pc, input logic pt,
                         input logic [31:0] tgt, input logic rv, input logic rt,
                         input logic [31:0] rtgt, input logic rst);
        logic ready;
        logic mis;
        br_t  e;
        enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_tgt = tgt;
        res_valid = rv; res_taken = rt; res_tgt = rtgt; reset = rst;
        if (rst) begin
            model_reset();
        end else begin
            ready   = model_ready();
            m_upd_v = 0;
            m_mis   = 0;
            if (rv && mq.size() == 0) m_err = 1;
            if (rv && mq.size() > 0) begin
                e   = mq.pop_front();
                mis = (rt != e.pt) || (rt && e.pt && rtgt != e.tgt);
                m_upd_v  = 1;
                m_upd_pc = e.pc;
                m_upd_t  = rt;
                m_redir  = rt ? rtgt : e.pc + 32'd4;
                m_mis    = mis;
                if (mis) mq.delete();
            end
            if (ev && ready && !m_mis) mq.push_back('{pc: pc, pt: pt, tgt: tgt});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        reset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
        checks++; if (upd_pc !== 32'h0) begin errors++; $display("FAIL reset_upd_pc got=%h exp=0", upd_pc); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got=%b exp=0", res_err); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    endtask

    task automatic test_taken_mispredict();
        cycle(1, 32'h100, 0, 32'h0, 0, 0, 0, 0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL t1_count_enq got=%0d exp=1", count); end
        cycle(0, 0, 0, 0, 1, 1, 32'h200, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL t1_mispredict got=%b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL t1_redirect got=%h exp=200", redirect_pc); end
        checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL t1_upd_taken got=%b exp=1", upd_taken); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL t1_upd_valid got=%b exp=1", upd_valid); end
        checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL t1_upd_pc got=%h exp=100", upd_pc); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_during_pulse got=%b exp=0", enq_ready); end
        idle();
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL t1_pulse_len got=%b exp=0", mispredict); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL t1_upd_len got=%b exp=0", upd_valid); end
    endtask

    task automatic test_correct_predict();
        cycle(1, 32'h104, 1, 32'h300, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 32'h300, 0);
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL t2_mispredict got=%b exp=0", mispredict); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL t2_upd_valid got=%b exp=1", upd_valid); end
        checks++; if (upd_pc !== 32'h104) begin errors++; $display("FAIL t2_upd_pc got=%h exp=104", upd_pc); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t2_count got=%0d exp=0", count); end
    endtask

    task automatic test_not_taken_mispredict();
        cycle(1, 32'h108, 1, 32'h300, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h0, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL t3_mispredict got=%b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h10C) begin errors++; $display("FAIL t3_redirect got=%h exp=10c", redirect_pc); end
        checks++; if (upd_taken !== 1'b0) begin errors++; $display("FAIL t3_upd_taken got=%b exp=0", upd_taken); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t3_count got=%0d exp=0", count); end
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) cycle(1, 32'h400 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL t4_count_full got=%0d exp=4", count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL t4_ready_full got=%b exp=0", enq_ready); end
        cycle(1, 32'h500, 0, 0, 1, 0, 0, 0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL t4_count_enq_res got=%0d exp=3", count); end
        checks++; if (upd_pc !== 32'h400 || upd_valid !== 1'b1) begin errors++; $display("FAIL t4_upd got=%h/%b exp=400/1", upd_pc, upd_valid); end
        // Held enqueue now fits; the oldest three remain in order.
        cycle(1, 32'h500, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (upd_pc !== ((i < 3) ? 32'h404 + 32'(4 * i) : 32'h500)) begin
                errors++; $display("FAIL t4_drain_order got=%h idx=%0d", upd_pc, i);
            end
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t4_count_drained got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1, 32'h600 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h700, 0, 0, 1, 1, 32'h800, 0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t5_count_flush got=%0d exp=0", count); end
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL t5_mispredict got=%b exp=1", mispredict); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL t5_ready_pulse got=%b exp=0", enq_ready); end
        cycle(1, 32'h700, 0, 0, 0, 0, 0, 0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t5_enq_dropped got=%0d exp=0", count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_after got=%b exp=1", enq_ready); end
    endtask

    task automatic test_empty_and_wrap();
        cycle(0, 0, 0, 0, 1, 1, 32'h900, 0);
        checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL t6_empty_pulse got=%b/%b exp=0/0", upd_valid, mispredict); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL t6_res_err got=%b exp=1", res_err); end
        cycle(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h0, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL t6_wrap_mispredict got=%b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL t6_wrap_redirect got=%h exp=0", redirect_pc); end
        idle();
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL t6_res_err_sticky got=%b exp=1", res_err); end
    endtask

    task automatic test_reset_midop();
        cycle(1, 32'hA00, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'hA04, 0, 0, 1, 1, 32'hB00, 1);
        reset = 0;
        checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got=%b/%b exp=0/0", upd_valid, mispredict); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL rst_mid_res_err got=%b exp=0", res_err); end
    endtask

    task automatic test_random();
        logic [31:0] tgts[4] = '{32'h200, 32'h300, 32'h1000, 32'hFFFF_FFF0};
        logic        ev, pt, rv, rt, rst;
        logic [31:0] pc, tgt, rtgt;
        for (int n = 0; n < 800; n++) begin
            ev   = ($urandom_range(0, 9) < 7);
            pc   = $urandom() & 32'hFFFF_FFFC;
            pt   = $urandom_range(0, 1);
            tgt  = tgts[$urandom_range(0, 3)];
            rv   = ($urandom_range(0, 9) < 4);
            rt   = $urandom_range(0, 1);
            rtgt = tgts[$urandom_range(0, 3)];
            rst  = ($urandom_range(0, 99) == 0);
            checks++; if (enq_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, enq_ready, model_ready()); end
            cycle(ev, pc, pt, tgt, rv, rt, rtgt, rst);
            checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
            checks++; if (mispredict !== m_mis || upd_valid !== m_upd_v) begin errors++; $display("FAIL rnd_pulses n=%0d got=%b/%b exp=%b/%b", n, mispredict, upd_valid, m_mis, m_upd_v); end
            checks++; if (res_err !== m_err) begin errors++; $display("FAIL rnd_res_err n=%0d got=%b exp=%b", n, res_err, m_err); end
            if (m_upd_v) begin
                checks++; if (upd_pc !== m_upd_pc || upd_taken !== m_upd_t) begin errors++; $display("FAIL rnd_upd n=%0d got=%h/%b exp=%h/%b", n, upd_pc, upd_taken, m_upd_pc, m_upd_t); end
            end
            if (m_mis) begin
                checks++; if (redirect_pc !== m_redir) begin errors++; $display("FAIL rnd_redirect n=%0d got=%h exp=%h", n, redirect_pc, m_redir); end
            end
        end
    endtask

    initial begin
        enq_valid = 0; enq_pc = 0; enq_pred_taken = 0; enq_pred_tgt = 0;
        res_valid = 0; res_taken = 0; res_tgt = 0; reset = 1;
        model_reset();
        test_reset();
        test_taken_mispredict();
        test_correct_predict();
        test_not_taken_mispredict();
        test_full();
        test_flush();
        test_empty_and_wrap();
        test_reset_midop();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
